dz_frame_scanner: RTL and testbench

Parametrised dot-matrix frame sequencer for the egg-hatch display path. It maps a game stage number to a frame index, and picks a random animal frame when the final stage is reached. It row-scans an external combinational frame ROM and drives the row and dual-colour column lines, recolouring and blinking the image on failure. It sits between the game controller, which supplies `stage`, `upd` and `fail`, and the matrix pins.

---
 rtl/dz_frame_scanner.sv | 142 ++++++++++++++
 tb/tb_dz_frame_scanner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dz_frame_scanner.sv
// Stage-to-frame sequencer and row scanner for the egg-hatch dot-matrix display.
// Drives one ROM row per SCAN_DIV clocks, red normally, blinking green on fail.
module dz_frame_scanner #(
  parameter int ROWS             = 8,
  parameter int COLS             = 8,
  parameter int STAGE_W          = 5,
  parameter int FINAL_STAGE      = 16,
  parameter int STAGES_PER_FRAME = 2,
  parameter int ANIMAL_BASE      = 8,
  parameter int NUM_ANIMALS      = 4,
  parameter int FRAME_W          = 4,
  parameter int SCAN_DIV         = 1000,
  parameter int BLINK_FRAMES     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      upd,
  input  logic [STAGE_W-1:0]        stage,
  input  logic                      fail,
  input  logic [COLS-1:0]           rom_data,
  output logic [FRAME_W-1:0]        frame_idx,
  output logic [$clog2(ROWS)-1:0]   row_addr,
  output logic [ROWS-1:0]           row,
  output logic [COLS-1:0]           colg,
  output logic [COLS-1:0]           colr,
  output logic                      upd_pend,
  output logic                      err
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int AN_W  = $clog2(NUM_ANIMALS);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [STAGE_W-1:0] FINAL_S = STAGE_W'(FINAL_STAGE);

  logic [15:0]        lfsr_reg;
  logic               lfsr_fb;
  logic [DIV_W-1:0]   div_reg;
  logic [BLK_W-1:0]   blink_cnt_reg;
  logic               phase_reg;
  logic               animal_set_reg;
  logic [AN_W-1:0]    animal_off_reg;
  logic [FRAME_W-1:0] pend_frame_reg;

  logic [STAGE_W-1:0] stage_div;
  logic [FRAME_W-1:0] egg_frame;
  logic [AN_W-1:0]    draw_off;
  logic [FRAME_W-1:0] new_frame;
  logic               is_final;
  logic               upd_ok;
  logic               upd_bad;
  logic               div_tc;
  logic               boundary;
  logic [ROWS-1:0]    row_next;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  // Egg frames saturate at the last egg frame before the animal range.
  assign stage_div = stage / STAGE_W'(STAGES_PER_FRAME);
  assign egg_frame = (stage_div > STAGE_W'(ANIMAL_BASE - 1)) ?
                     FRAME_W'(ANIMAL_BASE - 1) : FRAME_W'(stage_div);

  assign is_final  = (stage == FINAL_S);
  assign upd_ok    = upd && (stage <= FINAL_S);
  assign upd_bad   = upd && (stage > FINAL_S);
  // Once drawn, the animal sticks until a lower stage clears it.
  assign draw_off  = animal_set_reg ? animal_off_reg : lfsr_reg[AN_W-1:0];
  assign new_frame = is_final ? (FRAME_W'(ANIMAL_BASE) + FRAME_W'(draw_off)) : egg_frame;

  assign div_tc    = (div_reg == DIV_W'(SCAN_DIV - 1));
  assign boundary  = div_tc && (row_addr == ROW_W'(ROWS - 1));

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_dec
    assign row_next[gi] = (row_addr == ROW_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg       <= 16'hACE1;
      div_reg        <= '0;
      row_addr       <= '0;
      animal_set_reg <= 1'b0;
      animal_off_reg <= '0;
      pend_frame_reg <= '0;
      frame_idx      <= '0;
      upd_pend       <= 1'b0;
      err            <= 1'b0;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
      err      <= upd_bad;
      div_reg  <= div_tc ? '0 : div_reg + DIV_W'(1);
      if (div_tc) begin
        row_addr <= row_addr + ROW_W'(1);
      end
      if (upd_ok) begin
        animal_set_reg <= is_final;
        animal_off_reg <= draw_off;
      end
      // An update landing on the boundary bypasses the pending register.
      if (boundary) begin
        if (upd_ok) begin
          frame_idx <= new_frame;
        end else if (upd_pend) begin
          frame_idx <= pend_frame_reg;
        end
        upd_pend <= 1'b0;
      end else if (upd_ok) begin
        pend_frame_reg <= new_frame;
        upd_pend       <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (!fail) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (boundary) begin
      if (blink_cnt_reg == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      colg <= '0;
      colr <= '0;
    end else begin
      row  <= row_next;
      colr <= fail ? '0 : rom_data;
      colg <= (fail && !phase_reg) ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_dz_frame_scanner.sv
// Scoreboard bench for dz_frame_scanner: frame changes and err pulses are
// checked by a monitor against queued expectations; pixels every cycle.
module tb_dz_frame_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upd = 1'b0;
  logic       fail = 1'b0;
  logic [4:0] stage = 5'd0;
  logic [7:0] rom_data;
  logic [3:0] frame_idx;
  logic [2:0] row_addr;
  logic [7:0] row, colg, colr;
  logic       upd_pend, err;

  always #5 clk = ~clk;

  dz_frame_scanner #(
    .ROWS(8), .COLS(8), .STAGE_W(5), .FINAL_STAGE(16), .STAGES_PER_FRAME(2),
    .ANIMAL_BASE(8), .NUM_ANIMALS(4), .FRAME_W(4), .SCAN_DIV(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .upd(upd), .stage(stage), .fail(fail),
    .rom_data(rom_data), .frame_idx(frame_idx), .row_addr(row_addr), .row(row),
    .colg(colg), .colr(colr), .upd_pend(upd_pend), .err(err)
  );

  // Frame ROM: never all-zero, so a dark column is always distinguishable.
  function automatic logic [7:0] rom_fn(input logic [3:0] f, input logic [2:0] r);
    return {f, 1'b1, r};
  endfunction
  assign rom_data = rom_fn(frame_idx, row_addr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                     input bit quiet = 1'b0);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end else if (!quiet) begin
      $display("ok   %s: %0h at %0t", nm, act, $time);
    end
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  logic [3:0] exp_frame_q[$];
  int         err_q[$];
  int         exp_mode = 0;   // 0 red, 1 green
  bit         pix_en = 1'b0;

  // Monitor
  logic [2:0] prev_ra;
  logic [3:0] prev_fi, last_frame, ef;
  logic       err_prev;
  logic [7:0] er, ec;
  initial begin
    prev_ra = '0; prev_fi = '0; last_frame = '0; err_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_ra = '0; prev_fi = '0; last_frame = '0; err_prev = 1'b0;
      end else begin
        if (pix_en) begin
          er = 8'd1 << prev_ra;
          ec = rom_fn(prev_fi, prev_ra);
          chk("pix_row", row, er, 1'b1);
          chk("pix_colr", colr, (exp_mode == 0) ? ec : 8'h00, 1'b1);
          chk("pix_colg", colg, (exp_mode == 1) ? ec : 8'h00, 1'b1);
        end
        if (frame_idx !== last_frame) begin
          if (exp_frame_q.size() == 0) begin
            chk("frame_unexpected", frame_idx, last_frame);
          end else begin
            ef = exp_frame_q.pop_front();
            chk("frame_change", frame_idx, ef);
          end
          chk("frame_at_boundary", {prev_ra, row_addr}, {3'd7, 3'd0});
          last_frame = frame_idx;
        end
        if (err) begin
          if (err_q.size() == 0) begin
            chk("err_unexpected", err, 1'b0);
          end else begin
            void'(err_q.pop_front());
            chk("err_single_pulse", err_prev, 1'b0);
            chk("err_no_pend", upd_pend, 1'b0);
          end
        end
        prev_ra  = row_addr;
        prev_fi  = frame_idx;
        err_prev = err;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ra(input logic [2:0] v);
    int i = 0;
    while (row_addr !== v && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) chk("timeout_row_addr", row_addr, v);
  endtask

  task automatic wait_boundary();
    wait_ra(3'd7);
    wait_ra(3'd0);
  endtask

  task automatic issue(input logic [4:0] s);
    upd = 1'b1;
    stage = s;
    @(negedge clk);
    upd = 1'b0;
  endtask

  logic [3:0] a1, a2;
  int hold;

  initial begin
    // Reset state
    tick(2);
    chk("reset_row_cols", {row, colg, colr}, 24'h0);
    chk("reset_frame_addr", {frame_idx, row_addr, upd_pend, err}, 9'h0);
    rst_n = 1'b1;
    exp_mode = 0;
    pix_en = 1'b1;
    tick(1);
    chk("first_row", row, 8'h01);
    wait_ra(3'd2);
    hold = 0;
    while (row_addr == 3'd2 && hold < 20) begin
      hold++;
      tick(1);
    end
    chk("row_hold_cycles", hold, 4);

    // Stage 5 mid-scan -> frame 2 at the wrap
    wait_ra(3'd3);
    exp_frame_q.push_back(4'd2);
    issue(5'd5);
    chk("upd_pend_set", upd_pend, 1'b1);
    chk("frame_hold_mid_scan", frame_idx, 4'd0);
    wait_boundary();
    chk("upd_pend_clear", upd_pend, 1'b0);
    chk("frame_stage5", frame_idx, 4'd2);

    // Stage 15 -> frame 7 (saturated egg frame)
    wait_ra(3'd2);
    exp_frame_q.push_back(4'd7);
    issue(5'd15);
    wait_boundary();
    chk("frame_stage15", frame_idx, 4'd7);

    // Final stage: random animal, sticky, cleared by a lower stage, redrawn
    wait_ra(3'd2);
    a1 = 4'd8 + {2'b00, m_lfsr[1:0]};
    exp_frame_q.push_back(a1);
    issue(5'd16);
    wait_boundary();
    chk("animal_draw", frame_idx, a1);
    wait_ra(3'd2);
    issue(5'd16);
    wait_boundary();
    chk("animal_sticky", frame_idx, a1);
    wait_ra(3'd2);
    exp_frame_q.push_back(4'd1);
    issue(5'd3);
    wait_boundary();
    chk("frame_stage3", frame_idx, 4'd1);
    wait_ra(3'd2);
    a2 = 4'd8 + {2'b00, m_lfsr[1:0]};
    exp_frame_q.push_back(a2);
    issue(5'd16);
    wait_boundary();
    chk("animal_redraw", frame_idx, a2);

    // Two updates before one boundary: the last one wins
    wait_ra(3'd2);
    exp_frame_q.push_back(4'd4);
    issue(5'd5);
    tick(2);
    issue(5'd9);
    wait_boundary();
    chk("last_upd_wins", frame_idx, 4'd4);

    // Out-of-range stage
    wait_ra(3'd2);
    err_q.push_back(1);
    issue(5'd20);
    chk("err_pend_stays_0", upd_pend, 1'b0);
    tick(1);
    chk("err_one_cycle", err, 1'b0);
    wait_boundary();
    chk("err_frame_kept", frame_idx, 4'd4);

    // Update in the boundary cycle itself
    wait_ra(3'd7);
    tick(3);
    exp_frame_q.push_back(4'd1);
    issue(5'd2);
    chk("bnd_frame", frame_idx, 4'd1);
    chk("bnd_pend_never", upd_pend, 1'b0);
    tick(1);
    chk("bnd_pend_after", upd_pend, 1'b0);

    // Failure colouring and blink (2 frames on, 2 off)
    fail = 1'b1;
    exp_mode = 1;
    tick(3);
    pix_en = 1'b0;
    wait_boundary();
    wait_boundary();
    wait_ra(3'd3);
    tick(1);
    chk("blink_off_1", {colg, colr}, 16'h0);
    wait_boundary();
    wait_ra(3'd3);
    tick(1);
    chk("blink_off_2", {colg, colr}, 16'h0);
    wait_boundary();
    wait_ra(3'd3);
    tick(1);
    chk("blink_on_again", {colg, colr}, {rom_fn(frame_idx, 3'd3), 8'h00});
    fail = 1'b0;
    exp_mode = 0;
    pix_en = 1'b1;
    tick(1);
    chk("red_restored", {colg, colr}, {8'h00, rom_fn(frame_idx, row_addr)});

    // Asynchronous reset mid-row discards a pending update
    wait_ra(3'd3);
    issue(5'd7);
    chk("pend_before_reset", upd_pend, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_row_cols", {row, colg, colr}, 24'h0);
    chk("rst_mid_row_frame", {frame_idx, row_addr, upd_pend, err}, 9'h0);
    tick(2);
    rst_n = 1'b1;
    wait_boundary();
    chk("pending_discarded", frame_idx, 4'd0);
    chk("pend_after_reset", upd_pend, 1'b0);

    tick(2);
    chk("frame_queue_drained", exp_frame_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
